// File: rtl/neuro_serial_bridge.sv
// ============================================================================
// Module      : neuro_serial_bridge
// Description : Parallel/serial bridge for neuro_inference. It buffers and
//               bursts the weight image, serializes input samples, and
//               deserializes results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module neuro_serial_bridge #(
    parameter int N_W     = 250,
    parameter int W_CHUNK = 10,
    parameter int N_IN    = 14,
    parameter int N_OUT   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [W_CHUNK-1:0] w_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [N_IN-1:0]    s_data,
    output logic               d_in_serial,
    input  logic               out_serial,
    output logic               r_valid,
    input  logic               r_ready,
    output logic [N_OUT-1:0]   r_data,
    output logic               weights_loaded
);

    localparam int N_CHUNKS = N_W / W_CHUNK;
    localparam int CHUNK_W  = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int BIT_W    = $clog2(N_W + N_IN + N_OUT);

    localparam logic [CHUNK_W-1:0] c_last_chunk = CHUNK_W'(N_CHUNKS - 1);
    localparam logic [BIT_W-1:0]   c_last_wbit  = BIT_W'(N_W - 1);
    localparam logic [BIT_W-1:0]   c_last_ibit  = BIT_W'(N_IN - 1);
    localparam logic [BIT_W-1:0]   c_last_obit  = BIT_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        ST_LOAD_W  = 3'd0,
        ST_SEND_W  = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_SEND_IN = 3'd3,
        ST_GAP     = 3'd4,
        ST_RECV    = 3'd5,
        ST_RESULT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [CHUNK_W-1:0] chunk_cnt_q, chunk_cnt_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [N_W-1:0]     wbuf_q, wbuf_d;
    logic [N_W-1:0]     wbuf_in;
    logic [N_IN-1:0]    sample_q, sample_d;
    logic [N_OUT-1:0]   r_data_q, r_data_d;
    logic               d_in_serial_q, d_in_serial_d;
    logic               w_ready_q, w_ready_d;
    logic               s_ready_q, s_ready_d;
    logic               r_valid_q, r_valid_d;
    logic               weights_loaded_q, weights_loaded_d;

    always_comb begin
        state_d          = state_q;
        chunk_cnt_d      = chunk_cnt_q;
        bit_cnt_d        = bit_cnt_q;
        wbuf_d           = wbuf_q;
        sample_d         = sample_q;
        r_data_d         = r_data_q;
        d_in_serial_d    = d_in_serial_q;
        w_ready_d        = w_ready_q;
        s_ready_d        = s_ready_q;
        r_valid_d        = r_valid_q;
        weights_loaded_d = weights_loaded_q;
        wbuf_in          = {wbuf_q[N_W-W_CHUNK-1:0], w_data};

        case (state_q)
            ST_LOAD_W: begin
                if (w_valid && w_ready_q) begin
                    wbuf_d = wbuf_in;
                    if (chunk_cnt_q == c_last_chunk) begin
                        // First weight bit goes out in the cycle right after the last accept.
                        chunk_cnt_d   = '0;
                        bit_cnt_d     = '0;
                        w_ready_d     = 1'b0;
                        d_in_serial_d = wbuf_in[N_W-1];
                        state_d       = ST_SEND_W;
                    end else begin
                        chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
                    end
                end
            end
            ST_SEND_W: begin
                wbuf_d = wbuf_q << 1;
                if (bit_cnt_q == c_last_wbit) begin
                    bit_cnt_d        = '0;
                    d_in_serial_d    = 1'b0;
                    weights_loaded_d = 1'b1;
                    s_ready_d        = 1'b1;
                    state_d          = ST_WAIT_IN;
                end else begin
                    bit_cnt_d     = bit_cnt_q + BIT_W'(1);
                    d_in_serial_d = wbuf_q[N_W-2];
                end
            end
            ST_WAIT_IN: begin
                if (s_valid && s_ready_q) begin
                    sample_d      = s_data;
                    s_ready_d     = 1'b0;
                    d_in_serial_d = s_data[N_IN-1];
                    bit_cnt_d     = '0;
                    state_d       = ST_SEND_IN;
                end
            end
            ST_SEND_IN: begin
                sample_d = sample_q << 1;
                if (bit_cnt_q == c_last_ibit) begin
                    bit_cnt_d     = '0;
                    d_in_serial_d = 1'b0;
                    state_d       = ST_GAP;
                end else begin
                    bit_cnt_d     = bit_cnt_q + BIT_W'(1);
                    d_in_serial_d = sample_q[N_IN-2];
                end
            end
            ST_GAP: begin
                bit_cnt_d = '0;
                state_d   = ST_RECV;
            end
            ST_RECV: begin
                r_data_d = {r_data_q[N_OUT-2:0], out_serial};
                if (bit_cnt_q == c_last_obit) begin
                    bit_cnt_d = '0;
                    r_valid_d = 1'b1;
                    state_d   = ST_RESULT;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_RESULT: begin
                if (r_valid_q && r_ready) begin
                    r_valid_d = 1'b0;
                    s_ready_d = 1'b1;
                    state_d   = ST_WAIT_IN;
                end
            end
            default: begin
                state_d = ST_LOAD_W;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_LOAD_W;
            chunk_cnt_q      <= '0;
            bit_cnt_q        <= '0;
            wbuf_q           <= '0;
            sample_q         <= '0;
            r_data_q         <= '0;
            d_in_serial_q    <= 1'b0;
            w_ready_q        <= 1'b1;
            s_ready_q        <= 1'b0;
            r_valid_q        <= 1'b0;
            weights_loaded_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            chunk_cnt_q      <= chunk_cnt_d;
            bit_cnt_q        <= bit_cnt_d;
            wbuf_q           <= wbuf_d;
            sample_q         <= sample_d;
            r_data_q         <= r_data_d;
            d_in_serial_q    <= d_in_serial_d;
            w_ready_q        <= w_ready_d;
            s_ready_q        <= s_ready_d;
            r_valid_q        <= r_valid_d;
            weights_loaded_q <= weights_loaded_d;
        end
    end

    assign w_ready        = w_ready_q;
    assign s_ready        = s_ready_q;
    assign d_in_serial    = d_in_serial_q;
    assign r_valid        = r_valid_q;
    assign r_data         = r_data_q;
    assign weights_loaded = weights_loaded_q;

endmodule

`default_nettype wire

// File: tb/tb_neuro_serial_bridge.sv
// ============================================================================
// Module      : tb_neuro_serial_bridge
// Description : Directed self-checking bench for neuro_serial_bridge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neuro_serial_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_valid;
    logic        w_ready;
    logic [9:0]  w_data;
    logic        s_valid;
    logic        s_ready;
    logic [13:0] s_data;
    logic        d_in_serial;
    logic        out_serial;
    logic        r_valid;
    logic        r_ready;
    logic [12:0] r_data;
    logic        weights_loaded;

    int total = 0;
    int bad   = 0;

    bit          exp_bits[$];
    logic [12:0] exp_res[$];

    neuro_serial_bridge dut (
        .clk            (clk),
        .rst            (rst),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .d_in_serial    (d_in_serial),
        .out_serial     (out_serial),
        .r_valid        (r_valid),
        .r_ready        (r_ready),
        .r_data         (r_data),
        .weights_loaded (weights_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads 25 alternating chunks with random gaps, then checks the 250-bit burst.
    task automatic load_weights(input bit hold_s);
        logic [9:0] chunk;
        s_valid = hold_s;
        s_data  = 14'h1555;
        for (int i = 0; i < 25; i++) begin
            chunk = (i % 2 == 0) ? 10'h3FF : 10'h000;
            for (int b = 9; b >= 0; b--) exp_bits.push_back(chunk[b]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            w_valid = 1'b1;
            w_data  = chunk;
            check("w_ready_load", w_ready, 1);
            check("s_ready_load", s_ready, 0);
            @(negedge clk);
            w_valid = 1'b0;
        end
        s_valid = 1'b0;
        check("w_ready_after_last", w_ready, 0);
        for (int b = 0; b < 250; b++) begin
            check("weight_bit", d_in_serial, exp_bits.pop_front());
            if (b == 0) check("wl_during_burst", weights_loaded, 0);
            @(negedge clk);
        end
        check("burst_end_d", d_in_serial, 0);
        check("weights_loaded", weights_loaded, 1);
        check("w_ready_loaded", w_ready, 0);
        check("s_ready_loaded", s_ready, 1);
    endtask

    // One sample: handshake, check serial bits and gap, act as the core's result driver.
    task automatic run_sample(input logic [13:0] s, input logic [12:0] res, input bit ready_hi);
        int n;
        logic [12:0] exp;
        s_valid = 1'b1;
        s_data  = s;
        r_ready = ready_hi;
        exp_res.push_back(res);
        n = 0;
        while (s_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_hs", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0;
        for (int k = 0; k <= 28; k++) begin
            if (k <= 13) check("sample_bit", d_in_serial, s[13-k]);
            else         check("idle_d", d_in_serial, 0);
            if (k == 0)  check("s_ready_busy", s_ready, 0);
            if (k < 28)  check("r_valid_early", r_valid, 0);
            if (k >= 15 && k <= 27) out_serial = res[12-(k-15)];
            if (k < 28) @(negedge clk);
        end
        out_serial = 1'b0;
        check("r_valid_set", r_valid, 1);
        exp = exp_res.pop_front();
        check("r_data", r_data, exp);
        if (ready_hi) begin
            @(negedge clk);
            check("r_valid_clear", r_valid, 0);
            check("s_ready_return", s_ready, 1);
        end
    endtask

    initial begin
        logic [12:0] held;
        rst        = 1'b1;
        w_valid    = 1'($urandom);
        w_data     = 10'($urandom);
        s_valid    = 1'($urandom);
        s_data     = 14'($urandom);
        out_serial = 1'($urandom);
        r_ready    = 1'($urandom);
        repeat (2) @(negedge clk);
        check("rst_d", d_in_serial, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_wl", weights_loaded, 0);
        check("rst_w_ready", w_ready, 1);
        check("rst_r_data", r_data, 0);
        rst        = 1'b0;
        w_valid    = 1'b0;
        s_valid    = 1'b0;
        out_serial = 1'b0;
        r_ready    = 1'b1;

        load_weights(1'b0);

        // Weights after loading are ignored.
        w_valid = 1'b1;
        w_data  = 10'h155;
        repeat (3) begin
            @(negedge clk);
            check("w_ready_ignored", w_ready, 0);
            check("d_idle_wait", d_in_serial, 0);
        end
        w_valid = 1'b0;

        run_sample(14'h2A5A, 13'h1ABC, 1'b1);

        // Backpressure on the result port.
        run_sample(14'h1234, 13'h0F0F, 1'b0);
        held = 13'h0F0F;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            check("bp_r_valid", r_valid, 1);
            check("bp_r_data", r_data, held);
            check("bp_s_ready", s_ready, 0);
            check("bp_d", d_in_serial, 0);
        end
        r_ready = 1'b1;
        @(negedge clk);
        check("bp_release_r_valid", r_valid, 0);
        check("bp_release_s_ready", s_ready, 1);

        run_sample(14'h3FFF, 13'h1555, 1'b1);
        run_sample(14'h0001, 13'h0AAA, 1'b1);

        // Reset in the middle of sample serialization.
        s_valid = 1'b1;
        s_data  = 14'h3C3C;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_d", d_in_serial, 0);
        check("mid_rst_wl", weights_loaded, 0);
        check("mid_rst_w_ready", w_ready, 1);
        check("mid_rst_r_valid", r_valid, 0);
        s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("load_s_ready", s_ready, 0);
            check("load_d", d_in_serial, 0);
        end

        load_weights(1'b1);
        run_sample(14'h0F0F, 13'h0123, 1'b1);

        check("scoreboard_empty", exp_res.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
